// File: rtl/bkm_output_sequencer_if.sv
// Purpose : result-in / beat-out bundle between the BKM core, the output sequencer and the FPU port.
// Latency : none (wires only).
// Backpressure: in_valid/in_ready on the result side, out_valid/out_ready on the beat side.
// Signals:
//   in_valid, in_ready     result handshake from the BKM iteration core
//   format                 00 REAL_32, 01 REAL_64, 10 CMPLX_32, 11 CMPLX_64
//   X_in, Y_in             real / imaginary parts of the result
//   out_valid, out_ready   beat handshake towards the FPU result port
//   out_data               formatted beat
//   out_tag                0 = X beat, 1 = Y beat
//   out_last               final beat of the current result
// Modports: master = environment (drives results, consumes beats); slave = sequencer.
interface bkm_output_sequencer_if #(
   parameter int W = 64
);
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   format;
   logic [W-1:0] X_in;
   logic [W-1:0] Y_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_tag;
   logic         out_last;

   modport master (
      output in_valid, format, X_in, Y_in, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_last
   );

   modport slave (
      input  in_valid, format, X_in, Y_in, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_last
   );
endinterface

// File: rtl/bkm_output_sequencer.sv
// Purpose : serialise one BKM result (X, Y, format) onto a W-bit beat bus, X then Y for complex.
// Latency : result captured at edge N -> first beat valid after edge N; 2 cycles/real, 3 cycles/complex peak.
// Backpressure: beats hold stable while out_ready is low; in_ready is high only in IDLE (registered state).
// Ports:
//   clk              posedge clock
//   srst             synchronous reset, active high, wins over every handshake
//   bus (slave)      result input and beat output handshakes, see bkm_output_sequencer_if
//   busy_o           a result is held (state != IDLE)
//   result_count_o   results fully delivered, wraps modulo 2**CNT_W
module bkm_output_sequencer #(
   parameter int W     = 64,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     srst,
   bkm_output_sequencer_if.slave    bus,
   output logic                     busy_o,
   output logic [CNT_W-1:0]         result_count_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND_X = 2'd1,
      SEND_Y = 2'd2
   } state_t;

   // format[1] = complex, format[0] = 64-bit operand
   localparam int FMT_CPLX = 1;
   localparam int FMT_WIDE = 0;

   state_t             state_q,    state_d;
   logic [1:0]         fmt_q,      fmt_d;
   logic [W-1:0]       y_q,        y_d;
   logic [W-1:0]       out_data_q, out_data_d;
   logic               out_tag_q,  out_tag_d;
   logic               out_last_q, out_last_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;

   // 32-bit formats live in the low half; the beat carries them sign-extended.
   function automatic logic [W-1:0] sext_half(input logic [W-1:0] v);
      return {{(W/2){v[W/2-1]}}, v[W/2-1:0]};
   endfunction

   function automatic logic [W-1:0] fmt_beat(input logic [W-1:0] v, input logic wide);
      return wide ? v : sext_half(v);
   endfunction

   // The X beat is formatted straight from X_in at capture, so only Y needs
   // to be held until the second beat of a complex result.
   always_comb begin
      state_d    = state_q;
      fmt_d      = fmt_q;
      y_d        = y_q;
      out_data_d = out_data_q;
      out_tag_d  = out_tag_q;
      out_last_d = out_last_q;
      cnt_d      = cnt_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               fmt_d      = bus.format;
               y_d        = bus.Y_in;
               out_data_d = fmt_beat(bus.X_in, bus.format[FMT_WIDE]);
               out_tag_d  = 1'b0;
               out_last_d = ~bus.format[FMT_CPLX];
               state_d    = SEND_X;
            end
         end

         SEND_X: begin
            if (bus.out_ready) begin
               if (fmt_q[FMT_CPLX]) begin
                  out_data_d = fmt_beat(y_q, fmt_q[FMT_WIDE]);
                  out_tag_d  = 1'b1;
                  out_last_d = 1'b1;
                  state_d    = SEND_Y;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = IDLE;
               end
            end
         end

         SEND_Y: begin
            if (bus.out_ready) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q    <= IDLE;
         fmt_q      <= '0;
         y_q        <= '0;
         out_data_q <= '0;
         out_tag_q  <= 1'b0;
         out_last_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         fmt_q      <= fmt_d;
         y_q        <= y_d;
         out_data_q <= out_data_d;
         out_tag_q  <= out_tag_d;
         out_last_q <= out_last_d;
         cnt_q      <= cnt_d;
      end
   end

   // in_ready depends on registered state only, never on out_ready.
   assign bus.in_ready    = (state_q == IDLE);
   assign bus.out_valid   = (state_q == SEND_X) || (state_q == SEND_Y);
   assign bus.out_data    = out_data_q;
   assign bus.out_tag     = out_tag_q;
   assign bus.out_last    = out_last_q;
   assign busy_o          = (state_q != IDLE);
   assign result_count_o  = cnt_q;

endmodule

// File: tb/tb_bkm_output_sequencer.sv
module tb_bkm_output_sequencer;
   localparam int W     = 64;
   localparam int CNT_W = 4;

   logic             clk;
   logic             srst;
   logic             busy;
   logic [CNT_W-1:0] result_count;

   int checks   = 0;
   int failures = 0;

   bkm_output_sequencer_if #(.W(W)) bus ();

   bkm_output_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .srst           (srst),
      .bus            (bus.slave),
      .busy_o         (busy),
      .result_count_o (result_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs are driven and outputs sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_beat(input string tag, input logic [W-1:0] data,
                           input logic tag_bit, input logic last);
      chk({tag, "_valid"}, W'(bus.out_valid), W'(1));
      chk({tag, "_data"},  bus.out_data, data);
      chk({tag, "_tag"},   W'(bus.out_tag), W'(tag_bit));
      chk({tag, "_last"},  W'(bus.out_last), W'(last));
   endtask

   logic [W-1:0] xk;
   int           exp_cnt;

   initial begin
      srst          = 1'b1;
      bus.in_valid  = 1'b0;
      bus.format    = 2'b00;
      bus.X_in      = '0;
      bus.Y_in      = '0;
      bus.out_ready = 1'b0;
      exp_cnt       = 0;
      tick(); tick();
      srst = 1'b0;

      // Reset state
      chk("rst_in_ready",  W'(bus.in_ready), W'(1));
      chk("rst_out_valid", W'(bus.out_valid), W'(0));
      chk("rst_out_data",  bus.out_data, '0);
      chk("rst_out_tag",   W'(bus.out_tag), W'(0));
      chk("rst_out_last",  W'(bus.out_last), W'(0));
      chk("rst_busy",      W'(busy), W'(0));
      chk("rst_count",     W'(result_count), W'(0));

      // 1: REAL_32 with bit 31 set -> sign-extended single beat
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.format    = 2'b00;
      bus.X_in      = 64'h0000_0000_8000_0001;
      bus.Y_in      = 64'h5555_5555_5555_5555;
      tick();
      bus.in_valid = 1'b0;
      chk_beat("t1_x", 64'hFFFF_FFFF_8000_0001, 1'b0, 1'b1);
      chk("t1_in_ready", W'(bus.in_ready), W'(0));
      chk("t1_busy",     W'(busy), W'(1));
      tick();
      exp_cnt = 1;
      chk("t1_idle_valid", W'(bus.out_valid), W'(0));
      chk("t1_idle_ready", W'(bus.in_ready), W'(1));
      chk("t1_count",      W'(result_count), W'(exp_cnt));

      // 2: CMPLX_64, two unmodified beats
      bus.in_valid = 1'b1;
      bus.format   = 2'b11;
      bus.X_in     = 64'h1;
      bus.Y_in     = 64'h2;
      tick();
      bus.in_valid = 1'b0;
      chk_beat("t2_x", 64'h1, 1'b0, 1'b0);
      chk("t2_in_ready_x", W'(bus.in_ready), W'(0));
      tick();
      chk_beat("t2_y", 64'h2, 1'b1, 1'b1);
      chk("t2_in_ready_y", W'(bus.in_ready), W'(0));
      tick();
      exp_cnt = 2;
      chk("t2_idle_valid", W'(bus.out_valid), W'(0));
      chk("t2_idle_ready", W'(bus.in_ready), W'(1));
      chk("t2_count",      W'(result_count), W'(exp_cnt));

      // 3: CMPLX_32 with X beat stalled for 5 cycles
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.format    = 2'b10;
      bus.X_in      = 64'hABCD_0000_8765_4321;
      bus.Y_in      = 64'h0000_0000_FFFF_FFFE;
      tick();
      bus.in_valid = 1'b0;
      chk_beat("t3_x0", 64'hFFFF_FFFF_8765_4321, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_beat("t3_xhold", 64'hFFFF_FFFF_8765_4321, 1'b0, 1'b0);
      end
      chk("t3_count_stall", W'(result_count), W'(exp_cnt));
      bus.out_ready = 1'b1;
      tick();
      chk_beat("t3_y", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1);
      tick();
      exp_cnt = 3;
      chk("t3_count", W'(result_count), W'(exp_cnt));

      // 4: srst in SEND_Y, asserted together with out_ready
      bus.in_valid = 1'b1;
      bus.format   = 2'b11;
      bus.X_in     = 64'hAA;
      bus.Y_in     = 64'hBB;
      tick();
      bus.in_valid = 1'b0;
      chk_beat("t4_x", 64'hAA, 1'b0, 1'b0);
      tick();
      chk_beat("t4_y", 64'hBB, 1'b1, 1'b1);
      srst = 1'b1;
      tick();
      srst = 1'b0;
      exp_cnt = 0;
      chk("t4_out_valid", W'(bus.out_valid), W'(0));
      chk("t4_in_ready",  W'(bus.in_ready), W'(1));
      chk("t4_count",     W'(result_count), W'(exp_cnt));
      chk("t4_busy",      W'(busy), W'(0));
      chk("t4_out_data",  bus.out_data, '0);
      // out_ready while idle must do nothing
      tick(); tick();
      chk("t4_no_beat",   W'(bus.out_valid), W'(0));
      chk("t4_count_idle", W'(result_count), W'(exp_cnt));

      // 5: 17 back-to-back REAL_64 results with a 4-bit counter
      bus.format = 2'b01;
      for (int k = 0; k < 17; k++) begin
         xk = 64'h8000_0000_8000_0000 + 64'(k) * 64'h0101_0101_0101_0101;
         bus.in_valid = 1'b1;
         bus.X_in     = xk;
         tick();
         bus.in_valid = 1'b0;
         chk("t5_data", bus.out_data, xk);
         chk("t5_last", W'(bus.out_last), W'(1));
         tick();
      end
      exp_cnt = 1;
      chk("t5_count_wrap", W'(result_count), W'(exp_cnt));

      // 6: new result offered while SEND_X is stalled
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.format    = 2'b01;
      bus.X_in      = 64'h1111_1111_1111_1111;
      tick();
      bus.X_in = 64'h2222_2222_2222_2222;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_hold_data",  bus.out_data, 64'h1111_1111_1111_1111);
         chk("t6_hold_ready", W'(bus.in_ready), W'(0));
      end
      bus.out_ready = 1'b1;
      tick();
      exp_cnt = 2;
      chk("t6_gap_valid", W'(bus.out_valid), W'(0));
      chk("t6_gap_ready", W'(bus.in_ready), W'(1));
      chk("t6_count_a",   W'(result_count), W'(exp_cnt));
      tick();
      bus.in_valid = 1'b0;
      chk_beat("t6_b", 64'h2222_2222_2222_2222, 1'b0, 1'b1);
      tick();
      exp_cnt = 3;
      chk("t6_count_b",   W'(result_count), W'(exp_cnt));
      chk("t6_end_valid", W'(bus.out_valid), W'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
